// File: rtl/ll_threshold_detector.sv
// Hysteresis threshold detector for line-length samples: debounced onset/release
// with one-cycle onset/offset pulses and a saturating onset counter.
module ll_threshold_detector #(
  parameter int data_width = 31,
  parameter int cnt_width  = 8,
  parameter int evt_width  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [data_width:0]   din,
  input  logic signed [data_width:0]   thr_on,
  input  logic signed [data_width:0]   thr_off,
  input  logic        [cnt_width-1:0]  on_len,
  input  logic        [cnt_width-1:0]  off_len,
  output logic                         detect,
  output logic                         onset,
  output logic                         offset,
  output logic        [evt_width-1:0]  evt_count
);

  typedef enum logic [1:0] {QUIET, ARM, ACTIVE, DISARM} state_t;

  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};
  localparam logic [evt_width-1:0] EVT_ONE = {{(evt_width-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [cnt_width-1:0] r_cnt;
  logic                 r_detect;
  logic                 r_onset;
  logic                 r_offset;
  logic [evt_width-1:0] r_evt_count;

  logic                 w_hit;
  logic                 w_clear;
  logic [cnt_width-1:0] w_l_on;
  logic [cnt_width-1:0] w_l_off;
  logic [cnt_width-1:0] w_cnt_inc;

  function automatic logic [evt_width-1:0] sat_inc(input logic [evt_width-1:0] v);
    return (&v) ? v : v + EVT_ONE;
  endfunction

  assign w_hit     = (din >= thr_on);
  assign w_clear   = (din <  thr_off);
  // A programmed length of zero behaves as a single-sample run.
  assign w_l_on    = (on_len  == '0) ? CNT_ONE : on_len;
  assign w_l_off   = (off_len == '0) ? CNT_ONE : off_len;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= QUIET;
      r_cnt       <= '0;
      r_detect    <= 1'b0;
      r_onset     <= 1'b0;
      r_offset    <= 1'b0;
      r_evt_count <= '0;
    end else begin
      r_onset  <= 1'b0;
      r_offset <= 1'b0;
      if (en) begin
        case (r_state)
          QUIET: begin
            if (w_hit) begin
              if (w_l_on == CNT_ONE) begin
                r_state     <= ACTIVE;
                r_cnt       <= '0;
                r_detect    <= 1'b1;
                r_onset     <= 1'b1;
                r_evt_count <= sat_inc(r_evt_count);
              end else begin
                r_state <= ARM;
                r_cnt   <= CNT_ONE;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          ARM: begin
            if (w_hit) begin
              if (w_cnt_inc == w_l_on) begin
                r_state     <= ACTIVE;
                r_cnt       <= '0;
                r_detect    <= 1'b1;
                r_onset     <= 1'b1;
                r_evt_count <= sat_inc(r_evt_count);
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // Partial hit runs are discarded.
              r_state <= QUIET;
              r_cnt   <= '0;
            end
          end
          ACTIVE: begin
            if (w_clear) begin
              if (w_l_off == CNT_ONE) begin
                r_state  <= QUIET;
                r_cnt    <= '0;
                r_detect <= 1'b0;
                r_offset <= 1'b1;
              end else begin
                r_state <= DISARM;
                r_cnt   <= CNT_ONE;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          DISARM: begin
            if (w_clear) begin
              if (w_cnt_inc == w_l_off) begin
                r_state  <= QUIET;
                r_cnt    <= '0;
                r_detect <= 1'b0;
                r_offset <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ACTIVE;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= QUIET;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign detect    = r_detect;
  assign onset     = r_onset;
  assign offset    = r_offset;
  assign evt_count = r_evt_count;

endmodule

// File: tb/tb_ll_threshold_detector.sv
// Bench for ll_threshold_detector: directed vector table, saturation sequence on a
// 2-bit-counter instance, and randomized traffic against a run-length model.
module tb_ll_threshold_detector;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [31:0] din;
  logic signed [31:0] thr_on;
  logic signed [31:0] thr_off;
  logic [7:0]         on_len;
  logic [7:0]         off_len;

  logic        detect, onset, offset;
  logic [15:0] evt_count;
  logic        detect_s, onset_s, offset_s;
  logic [1:0]  evt_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  ll_threshold_detector #(.data_width(31), .cnt_width(8), .evt_width(16)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .thr_on(thr_on), .thr_off(thr_off),
    .on_len(on_len), .off_len(off_len), .detect(detect), .onset(onset),
    .offset(offset), .evt_count(evt_count)
  );

  ll_threshold_detector #(.data_width(31), .cnt_width(8), .evt_width(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .thr_on(thr_on), .thr_off(thr_off),
    .on_len(on_len), .off_len(off_len), .detect(detect_s), .onset(onset_s),
    .offset(offset_s), .evt_count(evt_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic               en;
    logic signed [31:0] din;
    logic signed [31:0] thr_on;
    logic signed [31:0] thr_off;
    logic [7:0]         on_len;
    logic [7:0]         off_len;
    logic               det;
    logic               on;
    logic               off;
    logic [15:0]        evt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic e, int d, int ton, int toff, int lon, int loff,
                              logic xd, logic xon, logic xoff, int xevt);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.thr_on = ton; v.thr_off = toff;
    v.on_len = 8'(lon); v.off_len = 8'(loff);
    v.det = xd; v.on = xon; v.off = xoff; v.evt = 16'(xevt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input int d, input int ton, input int toff,
                       input int lon, input int loff);
    rst = r; en = e; din = d; thr_on = ton; thr_off = toff;
    on_len = 8'(lon); off_len = 8'(loff);
  endtask

  // Behavioural model: track detect and the length of the current qualifying run.
  bit m_det;
  int m_run;
  int m_evt;
  bit m_on, m_off;

  task automatic model_step();
    int lon, loff;
    m_on  = 0;
    m_off = 0;
    if (!rst) begin
      m_det = 0; m_run = 0; m_evt = 0;
    end else if (en) begin
      lon  = (on_len  == 0) ? 1 : int'(on_len);
      loff = (off_len == 0) ? 1 : int'(off_len);
      if (!m_det) begin
        m_run = (din >= thr_on) ? m_run + 1 : 0;
        if (m_run >= lon) begin m_det = 1; m_on = 1; m_run = 0; m_evt++; end
      end else begin
        m_run = (din < thr_off) ? m_run + 1 : 0;
        if (m_run >= loff) begin m_det = 0; m_off = 1; m_run = 0; end
      end
    end
  endtask

  initial begin
    int ton, toff, lon, loff;
    drive(1'b0, 1'b0, 0, 1000, 600, 3, 2);

    // Reset, broken run, basic onset, hysteresis release.
    vq.push_back(mk(0, 0,    0, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1,  900, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1,    0, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1200, 1000, 600, 3, 2, 1, 1, 0, 1));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1, 1, 800, 1000, 600, 3, 2, 1, 0, 0, 1));
    vq.push_back(mk(1, 1,  500, 1000, 600, 3, 2, 1, 0, 0, 1));
    vq.push_back(mk(1, 1,  700, 1000, 600, 3, 2, 1, 0, 0, 1));
    vq.push_back(mk(1, 1,  500, 1000, 600, 3, 2, 1, 0, 0, 1));
    vq.push_back(mk(1, 1,  500, 1000, 600, 3, 2, 0, 0, 1, 1));
    vq.push_back(mk(1, 0,  500, 1000, 600, 3, 2, 0, 0, 0, 1));
    // Zero lengths with a gapped strobe.
    vq.push_back(mk(1, 1, 1000, 1000, 600, 0, 0, 1, 1, 0, 2));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1, 0, 5000, 1000, 600, 0, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 1,    0, 1000, 600, 0, 0, 0, 0, 1, 2));
    // Reset mid-event wins over en, then negative input.
    vq.push_back(mk(1, 1, 1000, 1000, 600, 0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 1000, 1000, 600, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, -2222,   0, 600, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, -2222,   0, 600, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].din, vq[i].thr_on, vq[i].thr_off,
            vq[i].on_len, vq[i].off_len);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_detect", i), 32'(detect),    32'(vq[i].det));
      chk($sformatf("vec%0d_onset",  i), 32'(onset),     32'(vq[i].on));
      chk($sformatf("vec%0d_offset", i), 32'(offset),    32'(vq[i].off));
      chk($sformatf("vec%0d_evt",    i), 32'(evt_count), 32'(vq[i].evt));
    end

    // Saturation on the 2-bit counter instance.
    drive(1'b0, 1'b0, 0, 1000, 600, 0, 0);
    @(posedge clk); #1;
    chk("sat_reset_evt", 32'(evt_count_s), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b1, 1200, 1000, 600, 0, 0);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_onset", k),  32'(onset_s),     32'd1);
      chk($sformatf("sat%0d_detect", k), 32'(detect_s),    32'd1);
      chk($sformatf("sat%0d_evt", k),    32'(evt_count_s), (k > 3) ? 32'd3 : 32'(k));
      drive(1'b1, 1'b1, 0, 1000, 600, 0, 0);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_offset", k), 32'(offset_s),    32'd1);
      chk($sformatf("sat%0d_onset0", k), 32'(onset_s),     32'd0);
    end

    // Randomized traffic; configuration only changes in reset cycles.
    ton = 1000; toff = 600; lon = 2; loff = 2;
    m_det = 0; m_run = 0; m_evt = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 0 || $urandom_range(0, 99) == 0) begin
        ton  = $urandom_range(0, 2000) - 200;
        toff = ton - $urandom_range(0, 800) + (($urandom_range(0, 9) == 0) ? 900 : 0);
        lon  = $urandom_range(0, 4);
        loff = $urandom_range(0, 4);
        drive(1'b0, $urandom_range(0, 1), 0, ton, toff, lon, loff);
      end else begin
        drive(1'b1, ($urandom_range(0, 3) != 0), $urandom_range(0, 3000) - 700,
              ton, toff, lon, loff);
      end
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_detect", c), 32'(detect),      32'(m_det));
      chk($sformatf("rnd%0d_onset",  c), 32'(onset),       32'(m_on));
      chk($sformatf("rnd%0d_offset", c), 32'(offset),      32'(m_off));
      chk($sformatf("rnd%0d_evt",    c), 32'(evt_count),   (m_evt > 65535) ? 32'd65535 : 32'(m_evt));
      chk($sformatf("rnd%0d_evts",   c), 32'(evt_count_s), (m_evt > 3) ? 32'd3 : 32'(m_evt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ll_threshold_detector.md
Name: ll_threshold_detector

Overview:
- Downstream consumer of the linelength stage.
- Takes each line-length value as it is produced and compares it against programmable on/off thresholds with hysteresis.
- Debounces the comparison with consecutive-sample counters and produces a registered event flag plus one-cycle onset/offset pulses.
- Keeps a saturating count of detected events for the readout logic.

Parameters:
- data_width, 31, MSB index of the line-length sample; data buses are data_width+1 bits wide, matching linelength.
- cnt_width, 8, width of the debounce length configs and the internal run counter.
- evt_width, 16, width of the saturating event counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  sample strobe; din is valid and consumed only in cycles where en=1.
- din  in  data_width+1  signed line-length value from linelength dout.
- thr_on  in  data_width+1  signed onset threshold; a sample "hits" when din >= thr_on.
- thr_off  in  data_width+1  signed release threshold; a sample "clears" when din < thr_off.
- on_len  in  cnt_width  consecutive hits required for onset; 0 is treated as 1.
- off_len  in  cnt_width  consecutive clears required for release; 0 is treated as 1.
- detect  out  1  registered event-active flag.
- onset  out  1  one-cycle pulse when detect rises.
- offset  out  1  one-cycle pulse when detect falls.
- evt_count  out  evt_width  number of onsets since reset; saturates at all-ones.

Behaviour:
- Reset (rst=0 at posedge):
  - state=QUIET, run counter=0.
  - detect=0, onset=0, offset=0, evt_count=0.
  - Reset takes priority over en in the same cycle.
  - Reset mid-event drops detect without an offset pulse.
- Compare and update timing:
  - All compares are signed, full width.
  - Config inputs are sampled live on every en cycle; they must be held static during operation.
  - Outputs update on the same posedge that samples en=1, so they are visible the cycle after the sample is presented.
  - onset and offset are high for exactly one cycle and are 0 in every other cycle, including cycles where en=0.
- en=0: state, counter, detect and evt_count hold.
- Effective lengths: L_on = max(on_len,1), L_off = max(off_len,1).
- State QUIET (detect=0), on en:
  - hit: cnt=1; if L_on=1 go to ACTIVE with onset=1, else go to ARM.
  - miss: stay in QUIET, cnt=0.
- State ARM (detect=0), on en:
  - hit: cnt=cnt+1; when the new cnt equals L_on, go to ACTIVE with onset=1 and cnt=0.
  - miss: go to QUIET, cnt=0; partial runs are discarded.
- State ACTIVE (detect=1), on en:
  - clear: cnt=1; if L_off=1 go to QUIET with offset=1, else go to DISARM.
  - not clear: stay in ACTIVE, cnt=0.
- State DISARM (detect=1), on en:
  - clear: cnt=cnt+1; when the new cnt equals L_off, go to QUIET with offset=1 and cnt=0.
  - not clear: go back to ACTIVE, cnt=0; no offset pulse.
- detect rules:
  - Goes to 1 in the same cycle that onset pulses.
  - Goes to 0 in the same cycle that offset pulses.
- evt_count:
  - Increments by 1 on each onset.
  - At all-ones it holds; onset still pulses.
- Counter overflow: cnt never exceeds max(L_on, L_off), because it is compared for equality and cleared on every transition.
- thr_off > thr_on is legal; the FSM applies the stated compares as written (no hysteresis). No other config checking is done.
- Negative din compares naturally: always a miss for thr_on >= 0, always a clear for thr_off > din.

Test Plan:
1. Basic onset.
   - Stimulus: thr_on=1000, thr_off=600, on_len=3, off_len=2; en every cycle; din=1200,1200,1200.
   - Required: onset pulses and detect goes to 1 at the edge sampling the third 1200; evt_count=1.
2. Broken run.
   - Stimulus: same config; din=1200,1200,900,1200,1200.
   - Required: no onset, detect=0 throughout, evt_count=0.
3. Hysteresis release.
   - Stimulus: from ACTIVE, din=800 (between thresholds) for 5 samples, then 500,700,500,500.
   - Required: detect stays 1 through the 800s and through 500,700; offset pulses and detect goes to 0 at the last 500.
4. Gapped en and zero lengths.
   - Stimulus: on_len=0, off_len=0; din=1000 with en=1, then three cycles en=0 with din=5000, then din=0 with en=1.
   - Required: onset at the first sample; state holds through the en=0 gap; offset at din=0.
5. Reset mid-event and negative input.
   - Stimulus: in ACTIVE, assert rst=0 for one cycle.
   - Required: detect=0, evt_count=0, and no offset pulse.
   - Stimulus: then din=-32'd2222 with thr_on=0.
   - Required: stays in QUIET.
6. Saturation.
   - Stimulus: evt_width=2; drive 5 onset/offset cycles.
   - Required: evt_count reads 1,2,3,3,3; onset pulses every time.
